// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: enables one RO, lets it settle, counts
// its synchronized rising edges over a gate window and reports the count.
module ro_measure_ctrl #(
    parameter int NUM_RO        = 8,
    parameter int SEL_W         = 3,
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              scan_mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic [CNT_W-1:0]  count_out,
    output logic [SEL_W-1:0]  count_sel,
    output logic              count_valid,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0]  LAST_CH     = SEL_W'(NUM_RO - 1);

    // Saturating increment: returns {overflow_flag, count}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             ovf,
                                               input logic             pulse);
        if (!pulse)
            return {ovf, c};
        if (&c)
            return {1'b1, c};
        return {ovf, c + CNT_W'(1)};
    endfunction

    state_t            state, state_n;
    logic [SEL_W-1:0]  chan, chan_n;
    logic              scan_q, scan_n;
    logic [GATE_W-1:0] gate_q, gate_n;
    logic [GATE_W-1:0] timer, timer_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              ovf_flag, ovf_n;
    logic [CNT_W-1:0]  count_out_n;
    logic [SEL_W-1:0]  count_sel_n;
    logic              overflow_n;
    logic              count_valid_n;
    logic [GATE_W-1:0] gate_last;
    logic [CNT_W:0]    inc_res;

    logic ro_mux_p0;
    logic sync_p1, sync_p2, prev_p3;
    logic edge_pulse;

    // ---- stage p0: channel mux -> p1/p2: 2-flop synchronizer -> p3: edge history
    assign ro_mux_p0 = ro_in[chan];

    always_ff @(posedge clk) begin
        sync_p1 <= ro_mux_p0;
        sync_p2 <= sync_p1;
        prev_p3 <= sync_p2;
    end

    assign edge_pulse = sync_p2 & ~prev_p3;

    // A zero gate length still measures for one cycle.
    assign gate_last = (gate_q == '0) ? '0 : gate_q - GATE_W'(1);
    assign inc_res   = sat_inc(cnt, ovf_flag, edge_pulse);

    always_comb begin
        state_n       = state;
        chan_n        = chan;
        scan_n        = scan_q;
        gate_n        = gate_q;
        timer_n       = timer;
        cnt_n         = cnt;
        ovf_n         = ovf_flag;
        count_out_n   = count_out;
        count_sel_n   = count_sel;
        overflow_n    = overflow;
        count_valid_n = 1'b0;

        case (state)
            S_IDLE: begin
                timer_n = '0;
                cnt_n   = '0;
                ovf_n   = 1'b0;
                if (start && !abort) begin
                    scan_n  = scan_mode;
                    gate_n  = gate_len;
                    chan_n  = scan_mode ? '0 : sel_in;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_n = '0;
                ovf_n = 1'b0;
                if (timer == SETTLE_LAST) begin
                    timer_n = '0;
                    state_n = S_MEASURE;
                end else begin
                    timer_n = timer + GATE_W'(1);
                end
            end
            S_MEASURE: begin
                {ovf_n, cnt_n} = inc_res;
                if (timer == gate_last) begin
                    // Result registers load here so they are visible during DONE.
                    timer_n       = '0;
                    state_n       = S_DONE;
                    count_out_n   = inc_res[CNT_W-1:0];
                    count_sel_n   = chan;
                    overflow_n    = inc_res[CNT_W];
                    count_valid_n = 1'b1;
                end else begin
                    timer_n = timer + GATE_W'(1);
                end
            end
            S_DONE: begin
                cnt_n   = '0;
                ovf_n   = 1'b0;
                timer_n = '0;
                if (!scan_q || chan == LAST_CH) begin
                    state_n = S_IDLE;
                end else begin
                    chan_n  = chan + SEL_W'(1);
                    state_n = S_SETTLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Abort drops the measurement in progress but keeps the last result.
        if (abort && state != S_IDLE) begin
            state_n       = S_IDLE;
            timer_n       = '0;
            cnt_n         = '0;
            ovf_n         = 1'b0;
            count_out_n   = count_out;
            count_sel_n   = count_sel;
            overflow_n    = overflow;
            count_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            chan        <= '0;
            scan_q      <= 1'b0;
            gate_q      <= '0;
            timer       <= '0;
            cnt         <= '0;
            ovf_flag    <= 1'b0;
            count_out   <= '0;
            count_sel   <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            state       <= state_n;
            chan        <= chan_n;
            scan_q      <= scan_n;
            gate_q      <= gate_n;
            timer       <= timer_n;
            cnt         <= cnt_n;
            ovf_flag    <= ovf_n;
            count_out   <= count_out_n;
            count_sel   <= count_sel_n;
            overflow    <= overflow_n;
            count_valid <= count_valid_n;
        end
    end

    always_comb begin
        ro_en = '0;
        if (state != S_IDLE)
            ro_en[chan] = 1'b1;
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Directed bench for ro_measure_ctrl: table of single-channel runs plus
// hand-written scan, saturation, abort, gate-zero and reset sequences.
module tb_ro_measure_ctrl;

    localparam int NUM_RO = 8;

    logic        clk = 1'b0;
    logic        rst, start, abort, scan_mode;
    logic [2:0]  sel_in;
    logic [15:0] gate_len;
    logic [7:0]  ro_in;

    logic [7:0]  ro_en;
    logic [15:0] count_out;
    logic [2:0]  count_sel;
    logic        count_valid, overflow, busy;

    logic [7:0]  ro_en_s;
    logic [3:0]  count_out_s;
    logic [2:0]  count_sel_s;
    logic        count_valid_s, overflow_s, busy_s;

    always #5 clk = ~clk;

    ro_measure_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .scan_mode(scan_mode),
        .sel_in(sel_in), .gate_len(gate_len), .ro_in(ro_in), .ro_en(ro_en),
        .count_out(count_out), .count_sel(count_sel), .count_valid(count_valid),
        .overflow(overflow), .busy(busy)
    );

    ro_measure_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .scan_mode(scan_mode),
        .sel_in(sel_in), .gate_len(gate_len), .ro_in(ro_in), .ro_en(ro_en_s),
        .count_out(count_out_s), .count_sel(count_sel_s), .count_valid(count_valid_s),
        .overflow(overflow_s), .busy(busy_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vld_seen = 0;
    int half_per[NUM_RO] = '{default: 0};
    int ph[NUM_RO] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (count_valid) vld_seen = vld_seen + 1;

    // Ring oscillator models: channel k toggles every half_per[k] clocks (0 = static low).
    initial ro_in = '0;
    always @(negedge clk) begin
        for (int k = 0; k < NUM_RO; k++) begin
            if (half_per[k] == 0) begin
                ro_in[k] = 1'b0;
                ph[k] = 0;
            end else begin
                ph[k] = ph[k] + 1;
                if (ph[k] >= half_per[k]) begin
                    ph[k] = 0;
                    ro_in[k] = ~ro_in[k];
                end
            end
        end
    end

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] gate;
        int          half;
        int          lat;
        int          lo;
        int          hi;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_valid(input int budget, output int tv, output bit ok);
        ok = 1'b0;
        tv = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (count_valid) begin
                ok = 1'b1;
                tv = cyc;
                break;
            end
        end
    endtask

    task automatic go(input logic sc, input logic [2:0] s, input logic [15:0] g, output int t0);
        @(negedge clk);
        scan_mode = sc;
        sel_in    = s;
        gate_len  = g;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int t0, tv;
        bit ok;
        for (int k = 0; k < NUM_RO; k++)
            half_per[k] = (k == int'(v.sel)) ? v.half : 9;
        go(1'b0, v.sel, v.gate, t0);
        chk({nm, "_busy"}, int'(busy), 1);
        wait_valid(3000, tv, ok);
        chk({nm, "_timeout"}, int'(ok), 1);
        if (ok) begin
            chk({nm, "_latency"}, tv - t0, v.lat);
            chk({nm, "_sel"}, int'(count_sel), int'(v.sel));
            chk_rng({nm, "_count"}, int'(count_out), v.lo, v.hi);
            chk({nm, "_ovf"}, int'(overflow), 0);
            chk({nm, "_ro_en"}, int'(ro_en), 1 << v.sel);
            @(negedge clk);
            chk({nm, "_busy_after"}, int'(busy), 0);
            chk({nm, "_ro_en_after"}, int'(ro_en), 0);
            chk({nm, "_valid_after"}, int'(count_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, tv, tprev, vs, c1, lo, hi, h;
        bit ok;

        tbl[0] = '{3'd3, 16'd100, 5, 117,  9, 11};
        tbl[1] = '{3'd0, 16'd0,   0,  18,  0,  0};
        tbl[2] = '{3'd7, 16'd40,  2,  57,  9, 11};
        tbl[3] = '{3'd5, 16'd1,   0,  18,  0,  0};
        tbl[4] = '{3'd1, 16'd64,  4,  81,  7,  9};
        tbl[5] = '{3'd6, 16'd30,  3,  47,  4,  6};

        rst = 1'b1; start = 1'b0; abort = 1'b0; scan_mode = 1'b0;
        sel_in = '0; gate_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ro_en", int'(ro_en), 0);
        chk("rst_count", int'(count_out), 0);
        chk("rst_sel", int'(count_sel), 0);
        chk("rst_valid", int'(count_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;

        // abort beats start in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1; sel_in = 3'd2; gate_len = 16'd10;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_prio_busy", int'(busy), 0);
        chk("abort_prio_ro_en", int'(ro_en), 0);

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // gate_len = 0, static input, start pulses while busy are ignored
        for (int k = 0; k < NUM_RO; k++) half_per[k] = 0;
        vs = vld_seen;
        go(1'b0, 3'd2, 16'd0, t0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_valid(100, tv, ok);
        chk("g0_timeout", int'(ok), 1);
        chk("g0_latency", tv - t0, 18);
        chk("g0_count", int'(count_out), 0);
        repeat (40) @(negedge clk);
        chk("g0_single_run", vld_seen - vs, 1);
        chk("g0_busy", int'(busy), 0);

        // saturation on the 4-bit instance
        for (int k = 0; k < NUM_RO; k++) half_per[k] = 0;
        half_per[2] = 3;
        go(1'b0, 3'd2, 16'd200, t0);
        wait_valid(400, tv, ok);
        chk("sat_timeout", int'(ok), 1);
        chk("sat_valid_s", int'(count_valid_s), 1);
        chk("sat_count_s", int'(count_out_s), 15);
        chk("sat_ovf_s", int'(overflow_s), 1);
        chk_rng("sat_count_wide", int'(count_out), 32, 34);
        chk("sat_ovf_wide", int'(overflow), 0);
        go(1'b0, 3'd2, 16'd20, t0);
        wait_valid(400, tv, ok);
        chk("sat2_timeout", int'(ok), 1);
        chk("sat2_ovf_s", int'(overflow_s), 0);
        chk_rng("sat2_count_s", int'(count_out_s), 2, 5);

        // full scan; sel_in must be ignored
        for (int k = 0; k < NUM_RO; k++) half_per[k] = k + 2;
        go(1'b1, 3'd5, 16'd50, t0);
        tprev = t0;
        for (int k = 0; k < NUM_RO; k++) begin
            wait_valid(200, tv, ok);
            chk($sformatf("scan%0d_timeout", k), int'(ok), 1);
            h = 2 * (k + 2);
            lo = 50 / h - 1;
            hi = (50 + h - 1) / h + 1;
            chk($sformatf("scan%0d_spacing", k), tv - tprev, 67);
            chk($sformatf("scan%0d_sel", k), int'(count_sel), k);
            chk($sformatf("scan%0d_ro_en", k), int'(ro_en), 1 << k);
            chk_rng($sformatf("scan%0d_count", k), int'(count_out), lo, hi);
            tprev = tv;
        end
        @(negedge clk);
        chk("scan_end_busy", int'(busy), 0);
        chk("scan_end_ro_en", int'(ro_en), 0);

        // abort during MEASURE of channel 2
        go(1'b1, 3'd0, 16'd50, t0);
        wait_valid(200, tv, ok);
        chk("abt_ch0_timeout", int'(ok), 1);
        wait_valid(200, tv, ok);
        chk("abt_ch1_timeout", int'(ok), 1);
        c1 = int'(count_out);
        repeat (20) @(negedge clk);
        chk("abt_pre_ro_en", int'(ro_en), 8'h04);
        chk("abt_pre_busy", int'(busy), 1);
        vs = vld_seen;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt_busy", int'(busy), 0);
        chk("abt_ro_en", int'(ro_en), 0);
        chk("abt_valid", int'(count_valid), 0);
        chk("abt_count_kept", int'(count_out), c1);
        chk("abt_sel_kept", int'(count_sel), 1);
        repeat (100) @(negedge clk);
        chk("abt_no_valid", vld_seen - vs, 0);

        // reset during SETTLE, then a normal run
        go(1'b0, 3'd4, 16'd30, t0);
        repeat (4) @(negedge clk);
        chk("rs_settle_ro_en", int'(ro_en), 8'h10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_busy", int'(busy), 0);
        chk("rs_ro_en", int'(ro_en), 0);
        chk("rs_count", int'(count_out), 0);
        chk("rs_sel", int'(count_sel), 0);
        chk("rs_ovf", int'(overflow), 0);
        chk("rs_valid", int'(count_valid), 0);
        chk("rs_count_s", int'(count_out_s), 0);
        chk("rs_busy_s", int'(busy_s), 0);
        chk("rs_ro_en_s", int'(ro_en_s), 0);
        chk("rs_sel_s", int'(count_sel_s), 0);
        run_vec(tbl[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ro_measure_ctrl.md
Name: ro_measure_ctrl

Overview:
- Measurement sequencer for a bank of ring oscillators on the tile.
- Enables one RO at a time and lets it settle.
- Counts its rising edges over a programmable gate window of `clk` cycles, then reports the count.
- Supports single-shot on a selected channel, or a scan of all channels in order; sits between the `ui_in` decode and the `uo_out` readout mux.

Parameters:
- NUM_RO, 8, number of ring oscillators controlled.
- SEL_W, 3, channel select width (clog2 of NUM_RO).
- CNT_W, 16, edge counter / result width.
- GATE_W, 16, gate length width.
- SETTLE_CYCLES, 16, RO start-up and synchronizer flush cycles before counting (min 3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a measurement; sampled only in IDLE.
- abort  in  1  cancel any measurement.
- scan_mode  in  1  0 = single channel `sel_in`; 1 = scan channels 0..NUM_RO-1. Latched at start.
- sel_in  in  SEL_W  channel for single mode. Latched at start.
- gate_len  in  GATE_W  gate window in `clk` cycles. Latched at start.
- ro_in  in  NUM_RO  raw RO outputs (pre-divided, asynchronous to `clk`).
- ro_en  out  NUM_RO  one-hot RO enable.
- count_out  out  CNT_W  last completed count.
- count_sel  out  SEL_W  channel that produced `count_out`.
- count_valid  out  1  one-cycle pulse when `count_out` updates.
- overflow  out  1  last count saturated.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all outputs 0, state IDLE, all counters 0.
- Front end: `ro_in[ch]` is muxed by the current channel, then passed through a 2-flop synchronizer, then a rising-edge detector (registered previous value).
- The synchronizer and edge register run in every state. The edge pulse is counted only in MEASURE.
- IDLE:
  - `ro_en` = 0.
  - On `start`=1 and `abort`=0: latch mode, `sel_in` and `gate_len`.
  - Current channel = `sel_in` in single mode, 0 in scan mode.
  - Next state SETTLE.
- SETTLE:
  - `ro_en` one-hot on the current channel.
  - Lasts exactly SETTLE_CYCLES cycles, then MEASURE.
  - Edge counter cleared, overflow cleared.
- MEASURE:
  - Lasts exactly max(gate_len,1) cycles; `gate_len`=0 is treated as 1.
  - Each cycle with an edge pulse increments the counter.
  - At all-ones the counter holds and the internal overflow flag sets.
- DONE (one cycle):
  - `count_out` <= counter, `count_sel` <= channel, `overflow` <= flag, `count_valid`=1.
  - Single mode, or scan mode on channel NUM_RO-1: `ro_en` cleared, next state IDLE.
  - Otherwise: channel+1, next state SETTLE, `ro_en` moves to the new channel.
- Latency: start accepted at cycle T gives `count_valid` at T+1+SETTLE_CYCLES+max(gate_len,1).
- `start` asserted while busy is ignored; it does not queue.
- `abort`:
  - In any non-IDLE state: next state IDLE, `ro_en` = 0, counter cleared, no `count_valid`.
  - `count_out`, `count_sel` and `overflow` keep their previous values.
  - `abort` has priority over `start` in the same cycle.
- `rst` mid-operation: same as the reset state, and `count_out` is cleared as well.
- `busy` deasserts in the cycle the state returns to IDLE.
- `ro_en` is never more than one-hot; it changes only at state boundaries.
- Input frequency contract: `ro_in` high and low phases each ≥ 2 `clk` periods; faster inputs alias and are out of scope.

Test Plan:
- Single, sel_in=3, gate_len=100, SETTLE_CYCLES=16, bench RO on ch3 toggling every 5 clk → `ro_en`=8'b0000_1000 during the run, count_out=10±1, count_sel=3, one count_valid pulse at start cycle +117, busy low the next cycle.
- Scan, gate_len=50, channel k toggles every (k+2) clk → 8 count_valid pulses, count_sel 0..7 in order, count_out ≈ 50/(2(k+2)), `ro_en` walks one-hot, then IDLE.
- Saturation: CNT_W=4, gate_len=200, RO toggling every 3 clk → count_out=15, overflow=1; next run with gate_len=20 → overflow=0.
- Abort in MEASURE of a scan at channel 2 → next cycle busy=0, `ro_en`=0, no count_valid, count_out still equals channel 1's result.
- gate_len=0 with static ro_in → MEASURE lasts 1 cycle, count_out=0, count_valid at start cycle +18; start pulses while busy produce no extra runs.
- Reset asserted during SETTLE → next cycle all outputs 0; a new start after reset runs normally.
